// File: rtl/spi_rr_arbiter_if.sv
// Purpose : bundles the requester-side and SPI-master-side signals of the
//           round-robin SPI arbiter.
// Ports   : master modport = arbiter view (drives gnt/rsp_*/busy/spi_wrt/spi_cmd)
//           slave  modport = client FSMs + SPI master view (drive req/cmd_in/spi_done/spi_rd_data)
interface spi_rr_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] cmd_in;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rsp_vld;
  logic [15:0]         rsp_data;
  logic                timeout_err;
  logic                busy;
  logic                spi_wrt;
  logic [15:0]         spi_cmd;
  logic                spi_done;
  logic [15:0]         spi_rd_data;

  modport master (
    input  req, cmd_in, spi_done, spi_rd_data,
    output gnt, rsp_vld, rsp_data, timeout_err, busy, spi_wrt, spi_cmd
  );

  modport slave (
    output req, cmd_in, spi_done, spi_rd_data,
    input  gnt, rsp_vld, rsp_data, timeout_err, busy, spi_wrt, spi_cmd
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Purpose : shares one 16-bit SPI master between N_REQ requesters with
//           round-robin arbitration, one transaction in flight, a minimum idle
//           gap after each completion and a watchdog on a missing done.
// Ports   : clk, rst_n (async active-low)
//           bus.master : req/cmd_in in, gnt/rsp_vld/rsp_data/timeout_err/busy out,
//                        spi_wrt/spi_cmd out, spi_done/spi_rd_data in
//
// state | meaning
// IDLE  | no transaction; pick a winner from req starting at ptr
// WAIT  | spi_wrt issued, waiting for a rising edge on spi_done or watchdog
// GAP   | rsp_vld issued, holding off the next spi_wrt for GAP_CYC cycles
module spi_rr_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic clk,
  input  logic rst_n,
  spi_rr_arbiter_if.master bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_GAP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              timeout_q, timeout_d;
  logic              spi_wrt_q, spi_wrt_d;
  logic [15:0]       spi_cmd_q, spi_cmd_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              done_q, done_d;
  logic [WW-1:0]     wdog_q, wdog_d;

  logic              arb_found;
  logic [PW-1:0]     arb_idx;
  int                cand;
  logic              done_rise;

  // Rotating priority scan: ptr first, then ptr+1, ... wrapping at N_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(cand);
      end
    end
  end

  // A done left high from the previous transfer looks like a rise in the
  // spi_wrt cycle because done_q is only tracked during WAIT.
  assign done_rise = bus.spi_done & ~done_q & ~spi_wrt_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    timeout_d  = 1'b0;
    spi_wrt_d  = 1'b0;
    spi_cmd_d  = spi_cmd_q;
    gap_d      = gap_q;
    done_d     = done_q;
    wdog_d     = wdog_q;

    // gnt stays up through the rsp_vld cycle and drops right after it.
    if (|rsp_vld_q) gnt_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          win_d     = arb_idx;
          gnt_d     = N_REQ'(1) << arb_idx;
          spi_wrt_d = 1'b1;
          spi_cmd_d = bus.cmd_in[16*arb_idx +: 16];
          wdog_d    = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        done_d = bus.spi_done;
        wdog_d = wdog_q + WW'(1);
        if (done_rise || wdog_q == WW'(TIMEOUT_CYC - 1)) begin
          rsp_vld_d  = gnt_q;
          rsp_data_d = done_rise ? bus.spi_rd_data : 16'hFFFF;
          timeout_d  = ~done_rise;
          ptr_d      = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
          gap_d      = GW'(GAP_CYC);
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      timeout_q  <= 1'b0;
      spi_wrt_q  <= 1'b0;
      spi_cmd_q  <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      timeout_q  <= timeout_d;
      spi_wrt_q  <= spi_wrt_d;
      spi_cmd_q  <= spi_cmd_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      wdog_q     <= wdog_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_vld     = rsp_vld_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.timeout_err = timeout_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.spi_wrt     = spi_wrt_q;
  assign bus.spi_cmd     = spi_cmd_q;

endmodule
